word_byte_serializer: RTL and testbench
=======================================

Name: word_byte_serializer

Overview:
- Sequential counterpart of the combinational word-to-byte bus split.
- Accepts one 32-bit word per valid/ready handshake and emits its bytes one per cycle, least-significant byte first, on a byte-wide valid/ready stream.
- Sits between the 32-bit datapath (PC/data words) and byte-wide consumers (byte memory port, UART-style sinks).
- A partial-word byte count lets the last word of a transfer carry 1-4 bytes.

Parameters:
- BYTE_W, 8, width of one byte lane.
- BYTES_PER_WORD, 4, byte lanes per input word; word width = BYTE_W*BYTES_PER_WORD.
- CNT_W, 3, width of in_byte_cnt; must hold BYTES_PER_WORD, i.e. clog2(BYTES_PER_WORD+1).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_word  input  32  word to serialize; byte k = in_word[8k+7:8k].
- in_byte_cnt  input  CNT_W  number of valid low-order bytes; 0 means BYTES_PER_WORD.
- in_valid  input  1  in_word/in_byte_cnt valid.
- in_ready  output  1  block can accept a word this cycle.
- out_byte  output  BYTE_W  current byte.
- out_valid  output  1  out_byte valid.
- out_ready  input  1  consumer accepts out_byte.
- out_first  output  1  out_byte is byte 0 of its word.
- out_last  output  1  out_byte is the final byte of its word.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - out_valid=0, out_byte=0, out_first=0, out_last=0.
  - Internal word register=0, idx=0, cnt=0, state=IDLE.
  - in_ready=0 while rst is high.
- States:
  - IDLE: no word held.
  - SEND: word held, idx selects the byte being presented.
- in_ready (combinational, rst=0) = (state==IDLE) | (out_valid & out_ready & out_last). Last-byte pass-through allows back-to-back words with no bubble.
- Input accept (in_valid & in_ready):
  - Register the word; cnt = (in_byte_cnt==0 || in_byte_cnt>BYTES_PER_WORD) ? BYTES_PER_WORD : in_byte_cnt.
  - idx=0, state=SEND.
  - out_valid=1 starting the next cycle. Latency is 1 cycle from input accept to first byte.
- Output presentation:
  - out_byte = word[idx*BYTE_W +: BYTE_W].
  - out_first = (idx==0).
  - out_last = (idx==cnt-1).
  - All outputs are registered or derived from registers only, never combinationally from in_*.
- Output transfer (out_valid & out_ready):
  - Not last byte: idx+1.
  - Last byte and a new word accepted the same cycle: load the new word, idx=0, stay in SEND.
  - Last byte, no new word: state=IDLE, out_valid=0 next cycle.
- Backpressure: while out_valid & !out_ready, out_byte, out_first, out_last and idx hold stable. out_valid never drops without a transfer, except on rst.
- in_valid is ignored when in_ready=0. The upstream must hold the word until it is accepted; the block does not check this.
- Single-byte word (cnt=1): out_first and out_last are both 1 on the same beat.
- Reset mid-word: remaining bytes are discarded; out_valid=0 on the cycle after rst is sampled high. No partial flush.
- Throughput: BYTES_PER_WORD bytes per BYTES_PER_WORD cycles sustained when out_ready is held high.

Decomposition:
- Shared package word_bus_pkg:
  - BYTE_W, BYTES_PER_WORD, WORD_W localparams.
  - State enum {IDLE, SEND}.
  - Byte-count width constant.
- Sub-module byte_lane_mux: combinational selection of byte lane idx from a word (parameterized BYTE_W/BYTES_PER_WORD). It is reusable by the matching byte-to-word packer.
- FSM, counter and handshake logic live in word_byte_serializer.

Test Plan:
- Word 0xDDCCBBAA, cnt=4, out_ready=1 -> out_byte AA,BB,CC,DD on 4 consecutive cycles starting 1 cycle after accept; out_first on AA only, out_last on DD only; state returns to IDLE.
- Words 0x44332211 then 0x88776655 offered back-to-back, out_ready=1 -> 8 consecutive bytes 11..88 with no gap; in_ready=1 on the cycle byte 44 transfers.
- Word 0xDDCCBBAA, out_ready low for 3 cycles while BB presented -> BB, out_first=0, out_last=0 stable for 4 cycles; CC follows after out_ready rises; in_ready=0 throughout.
- Word 0x12345678, cnt=2 -> bytes 78,56 only; out_last=1 on 56; next word accepted in the same cycle as 56.
- in_byte_cnt=0 with 0xCAFEBABE -> 4 bytes BE,BA,FE,CA; cnt=1 with 0x000000EE -> single byte EE with first=last=1.
- rst asserted after 2 bytes of 0xDDCCBBAA -> out_valid=0 next cycle, outputs 0; after rst falls in_ready=1 and a new word 0x0000A5A5 serializes from A5 with out_first=1.

Source files
------------

// File: rtl/word_bus_pkg.sv
// Shared widths and state encoding for the word <-> byte stream blocks.
package word_bus_pkg;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD + 1);
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/byte_lane_mux.sv
// Selects one byte lane of a word; shared with the byte-to-word packer.
module byte_lane_mux #(
  parameter int BYTE_W         = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int SEL_W          = $clog2(BYTES_PER_WORD)
) (
  input  logic [BYTE_W*BYTES_PER_WORD-1:0] word,
  input  logic [SEL_W-1:0]                 sel,
  output logic [BYTE_W-1:0]                lane
);
  logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] lanes;

  for (genvar g = 0; g < BYTES_PER_WORD; g++) begin : g_lane
    assign lanes[g] = word[g*BYTE_W +: BYTE_W];
  end

  assign lane = lanes[sel];
endmodule

// File: rtl/word_byte_serializer.sv
// Serializes one word per handshake into an LSB-first byte stream, with
// optional partial last word and no bubble between back-to-back words.
module word_byte_serializer
  import word_bus_pkg::*;
#(
  parameter int BYTE_W         = word_bus_pkg::BYTE_W,
  parameter int BYTES_PER_WORD = word_bus_pkg::BYTES_PER_WORD,
  parameter int CNT_W          = word_bus_pkg::CNT_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [BYTE_W*BYTES_PER_WORD-1:0] in_word,
  input  logic [CNT_W-1:0]                 in_byte_cnt,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [BYTE_W-1:0]                out_byte,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_first,
  output logic                             out_last
);
  localparam int SEL_W = $clog2(BYTES_PER_WORD);

  state_t                           state, state_nxt;
  logic [BYTE_W*BYTES_PER_WORD-1:0] word;
  logic [SEL_W-1:0]                 idx;
  logic [CNT_W-1:0]                 cnt;
  logic [CNT_W-1:0]                 cnt_norm;
  logic                             accept, xfer;

  assign out_valid = (state == SEND);
  assign out_first = out_valid && (idx == '0);
  assign out_last  = out_valid && (CNT_W'(idx) == cnt - CNT_W'(1));
  assign xfer      = out_valid && out_ready;
  assign in_ready  = !rst && ((state == IDLE) || (xfer && out_last));
  assign accept    = in_valid && in_ready;

  // Zero or out-of-range counts mean a full word.
  assign cnt_norm = (in_byte_cnt == '0 || in_byte_cnt > CNT_W'(BYTES_PER_WORD))
                    ? CNT_W'(BYTES_PER_WORD) : in_byte_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SEND;
      SEND: if (xfer && out_last && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      idx  <= '0;
      cnt  <= '0;
    end else if (accept) begin
      word <= in_word;
      idx  <= '0;
      cnt  <= cnt_norm;
    end else if (xfer && !out_last) begin
      idx <= idx + SEL_W'(1);
    end
  end

  byte_lane_mux #(
    .BYTE_W        (BYTE_W),
    .BYTES_PER_WORD(BYTES_PER_WORD)
  ) u_mux (
    .word(word),
    .sel (idx),
    .lane(out_byte)
  );
endmodule

// File: tb/tb_word_byte_serializer.sv
// Scoreboard bench: stimulus pushes expected bytes, a monitor pops them on
// every output transfer; directed checks cover latency, stalls and reset.
module tb_word_byte_serializer;
  logic        clk = 0;
  logic        rst;
  logic [31:0] in_word;
  logic [2:0]  in_byte_cnt;
  logic        in_valid, in_ready;
  logic [7:0]  out_byte;
  logic        out_valid, out_ready, out_first, out_last;

  typedef struct packed {logic [7:0] b; logic f; logic l;} exp_t;
  exp_t exp_q[$];
  int   xfer_cyc[$];
  int   tests = 0, fails = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  word_byte_serializer dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_byte_cnt(in_byte_cnt),
    .in_valid(in_valid), .in_ready(in_ready), .out_byte(out_byte),
    .out_valid(out_valid), .out_ready(out_ready), .out_first(out_first),
    .out_last(out_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output byte is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", {out_byte, out_first, out_last}, 32'hx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("byte",  out_byte,  e.b);
        chk("first", out_first, e.f);
        chk("last",  out_last,  e.l);
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input logic [2:0] c,
                           output int waits, output logic [7:0] seen);
    int n;
    exp_t e;
    n = (c == 0 || c > 4) ? 4 : int'(c);
    for (int k = 0; k < n; k++) begin
      e.b = w[8*k +: 8];
      e.f = (k == 0);
      e.l = (k == n - 1);
      exp_q.push_back(e);
    end
    in_word = w; in_byte_cnt = c; in_valid = 1; waits = 0;
    forever begin
      @(negedge clk);
      waits++;
      if (in_ready) break;
      if (waits > 50) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    seen = out_byte;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", t < 40, 1);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    int w; logic [7:0] s;
    rst = 1; in_valid = 0; in_word = 0; in_byte_cnt = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte",  out_byte,  0);
    chk("rst_first_last", {out_first, out_last}, 0);
    chk("rst_in_ready",  in_ready,  0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("idle_ready_after_rst", in_ready, 1);

    // Full word, 1-cycle latency to the first byte.
    @(posedge clk); #1;
    send_word(32'hDDCCBBAA, 3'd4, w, s);
    @(negedge clk);
    chk("latency_valid", out_valid, 1);
    chk("latency_byte",  out_byte, 8'hAA);
    wait_idle();

    // Back-to-back words, no gap.
    xfer_cyc.delete();
    @(posedge clk); #1;
    send_word(32'h44332211, 3'd4, w, s);
    send_word(32'h88776655, 3'd4, w, s);
    chk("b2b_accept_waits", w, 4);
    chk("b2b_accept_on_44", s, 8'h44);
    wait_idle();
    chk("b2b_count", xfer_cyc.size(), 8);
    for (int i = 1; i < xfer_cyc.size(); i++)
      chk("b2b_no_gap", xfer_cyc[i] - xfer_cyc[i-1], 1);

    // Backpressure while BB is presented.
    @(posedge clk); #1;
    send_word(32'hDDCCBBAA, 3'd4, w, s);
    @(posedge clk); #1 out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin @(posedge clk); #1 out_ready = 1; end
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_byte",  out_byte, 8'hBB);
      chk("stall_first_last", {out_first, out_last}, 0);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_next_cc", out_byte, 8'hCC);
    wait_idle();

    // Partial word, count 0 = full, single-byte word, chained.
    @(posedge clk); #1;
    send_word(32'h12345678, 3'd2, w, s);
    send_word(32'hCAFEBABE, 3'd0, w, s);
    chk("partial_accept_waits", w, 2);
    chk("partial_accept_on_56", s, 8'h56);
    send_word(32'h000000EE, 3'd1, w, s);
    chk("cnt0_accept_on_ca", s, 8'hCA);
    @(negedge clk);
    chk("single_byte", out_byte, 8'hEE);
    chk("single_first_last", {out_first, out_last}, 2'b11);
    wait_idle();

    // Reset mid-word discards the rest.
    @(posedge clk); #1;
    send_word(32'hDDCCBBAA, 3'd4, w, s);
    @(posedge clk);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_byte",  out_byte, 0);
    chk("midrst_first_last", {out_first, out_last}, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("postrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send_word(32'h0000A5A5, 3'd4, w, s);
    @(negedge clk);
    chk("postrst_byte",  out_byte, 8'hA5);
    chk("postrst_first", out_first, 1);
    wait_idle();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
